// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial arbiter between ICache fetches and LSB accesses.
// Owns the 8-bit RAM/IO port and assembles little-endian words.
module mem_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int IO_SEL_HI  = 17,
  parameter int IO_SEL_LO  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  jump_wrong,
  input  logic                  ic_req,
  input  logic [ADDR_WIDTH-1:0] ic_addr,
  output logic                  ic_done,
  output logic [31:0]           ic_data,
  input  logic                  ls_req,
  input  logic                  ls_we,
  input  logic [ADDR_WIDTH-1:0] ls_addr,
  input  logic [1:0]            ls_size,
  input  logic [31:0]           ls_wdata,
  output logic                  ls_done,
  output logic [31:0]           ls_rdata,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_wr,
  input  logic                  io_buffer_full
);

  typedef enum logic [1:0] {
    IDLE,
    IC_RD,
    LS_RD,
    LS_WR
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [2:0]            r_cnt;
  logic [2:0]            r_n;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [31:0]           r_wdata;
  logic [31:0]           r_buf;
  logic [31:0]           r_ic_data;
  logic [31:0]           r_ls_rdata;
  logic                  r_ic_done;
  logic                  r_ls_done;

  logic [ADDR_WIDTH-1:0] w_addr;
  logic                  w_io;
  logic                  w_stall;
  logic [1:0]            w_lidx;
  logic [31:0]           w_buf;
  logic [2:0]            w_ls_n;
  logic                  w_rd_last;
  logic                  w_wr_last;

  assign w_addr    = r_base + ADDR_WIDTH'(r_cnt);
  assign w_io      = &w_addr[IO_SEL_HI:IO_SEL_LO];
  assign w_stall   = (r_state == LS_WR) && w_io && io_buffer_full;
  assign w_lidx    = r_cnt[1:0] - 2'd1;
  assign w_ls_n    = (ls_size == 2'd0) ? 3'd1 :
                     (ls_size == 2'd1) ? 3'd2 : 3'd4;
  assign w_rd_last = (r_cnt == r_n);
  assign w_wr_last = (r_cnt == r_n - 3'd1);

  assign ic_done  = r_ic_done;
  assign ls_done  = r_ls_done;
  assign ic_data  = r_ic_data;
  assign ls_rdata = r_ls_rdata;

  // Byte arriving now belongs to lane cnt-1 (RAM has one cycle of latency).
  always_comb begin
    w_buf = r_buf;
    w_buf[{w_lidx, 3'b000} +: 8] = mem_din;
  end

  always_comb begin
    w_next   = r_state;
    mem_a    = '0;
    mem_wr   = 1'b0;
    mem_dout = 8'h00;
    unique case (r_state)
      IDLE: begin
        if (ls_req && !r_ls_done)
          w_next = ls_we ? LS_WR : LS_RD;
        else if (ic_req && !r_ic_done && !jump_wrong)
          w_next = IC_RD;
      end
      IC_RD: begin
        mem_a = w_addr;
        if (jump_wrong || w_rd_last)
          w_next = IDLE;
      end
      LS_RD: begin
        mem_a = w_addr;
        if (w_rd_last)
          w_next = IDLE;
      end
      LS_WR: begin
        mem_a    = w_addr;
        mem_dout = r_wdata[{r_cnt[1:0], 3'b000} +: 8];
        mem_wr   = rdy && !w_stall;
        if (!w_stall && w_wr_last)
          w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= 3'd0;
      r_n        <= 3'd0;
      r_base     <= '0;
      r_wdata    <= 32'h0;
      r_buf      <= 32'h0;
      r_ic_data  <= 32'h0;
      r_ls_rdata <= 32'h0;
      r_ic_done  <= 1'b0;
      r_ls_done  <= 1'b0;
    end else if (rdy) begin
      r_state   <= w_next;
      r_ic_done <= 1'b0;
      r_ls_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          r_cnt <= 3'd0;
          r_buf <= 32'h0;
          if (w_next == IC_RD) begin
            r_base <= ic_addr;
            r_n    <= 3'd4;
          end else if (w_next != IDLE) begin
            r_base  <= ls_addr;
            r_n     <= w_ls_n;
            r_wdata <= ls_wdata;
          end
        end
        IC_RD, LS_RD: begin
          if (!(r_state == IC_RD && jump_wrong)) begin
            r_cnt <= r_cnt + 3'd1;
            if (r_cnt != 3'd0)
              r_buf <= w_buf;
            if (w_rd_last) begin
              if (r_state == IC_RD) begin
                r_ic_done <= 1'b1;
                r_ic_data <= w_buf;
              end else begin
                r_ls_done  <= 1'b1;
                r_ls_rdata <= w_buf;
              end
            end
          end
        end
        LS_WR: begin
          if (!w_stall) begin
            r_cnt <= r_cnt + 3'd1;
            if (w_wr_last)
              r_ls_done <= 1'b1;
          end
        end
        default: r_cnt <= 3'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed checks of mem_ctrl against a byte RAM model.
// RAM answers one cycle after the address and freezes with rdy.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        jump_wrong = 1'b0;
  logic        ic_req = 1'b0;
  logic [31:0] ic_addr = 32'h0;
  logic        ic_done;
  logic [31:0] ic_data;
  logic        ls_req = 1'b0;
  logic        ls_we = 1'b0;
  logic [31:0] ls_addr = 32'h0;
  logic [1:0]  ls_size = 2'd0;
  logic [31:0] ls_wdata = 32'h0;
  logic        ls_done;
  logic [31:0] ls_rdata;
  logic [7:0]  mem_din = 8'h00;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full = 1'b0;

  logic [7:0]  ram [0:262143];
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  mem_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy), .jump_wrong(jump_wrong),
    .ic_req(ic_req), .ic_addr(ic_addr),
    .ic_done(ic_done), .ic_data(ic_data),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr),
    .ls_size(ls_size), .ls_wdata(ls_wdata),
    .ls_done(ls_done), .ls_rdata(ls_rdata),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a),
    .mem_wr(mem_wr), .io_buffer_full(io_buffer_full)
  );

  always @(posedge clk) begin
    if (rdy) begin
      if (mem_wr) ram[mem_a[17:0]] <= mem_dout;
      mem_din <= ram[mem_a[17:0]];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 262144; i++) ram[i] = 8'h00;
    ram[18'h100] = 8'h13; ram[18'h101] = 8'h05;
    ram[18'h102] = 8'h00; ram[18'h103] = 8'h00;
    ram[18'h200] = 8'hFF;
    ram[18'h300] = 8'hEF; ram[18'h301] = 8'hBE;
    ram[18'h302] = 8'hAD; ram[18'h303] = 8'hDE;
    ram[18'h050] = 8'h11; ram[18'h051] = 8'h22;
    ram[18'h052] = 8'h33; ram[18'h053] = 8'h44;
    ram[18'h3FFFF] = 8'h12; ram[18'h00000] = 8'h34;

    // reset
    step(); step();
    chk("rst_ic_done", {31'b0, ic_done}, 32'h0);
    chk("rst_ls_done", {31'b0, ls_done}, 32'h0);
    chk("rst_ic_data", ic_data, 32'h0);
    chk("rst_ls_rdata", ls_rdata, 32'h0);
    chk("rst_mem_a", mem_a, 32'h0);
    chk("rst_mem_wr", {31'b0, mem_wr}, 32'h0);
    chk("rst_mem_dout", {24'b0, mem_dout}, 32'h0);
    rst = 1'b0;
    step();

    // word fetch
    ic_req = 1'b1; ic_addr = 32'h100;
    step();
    ic_req = 1'b0;
    chk("wf_a0", mem_a, 32'h100);
    chk("wf_wr0", {31'b0, mem_wr}, 32'h0);
    step(); chk("wf_a1", mem_a, 32'h101);
    step(); chk("wf_a2", mem_a, 32'h102);
    step(); chk("wf_a3", mem_a, 32'h103);
    step(); chk("wf_done5", {31'b0, ic_done}, 32'h0);
    step(); chk("wf_done6", {31'b0, ic_done}, 32'h1);
    chk("wf_data", ic_data, 32'h00000513);
    step(); chk("wf_done7", {31'b0, ic_done}, 32'h0);
    chk("wf_hold", ic_data, 32'h00000513);

    // collision: LS wins, IC follows
    ic_req = 1'b1; ic_addr = 32'h100;
    ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'd0; ls_addr = 32'h200;
    step();
    ls_req = 1'b0;
    chk("col_a_ls", mem_a, 32'h200);
    step(); chk("col_ls_done2", {31'b0, ls_done}, 32'h0);
    step(); chk("col_ls_done3", {31'b0, ls_done}, 32'h1);
    chk("col_ls_rdata", ls_rdata, 32'h000000FF);
    chk("col_idle_a", mem_a, 32'h0);
    step();
    ic_req = 1'b0;
    chk("col_ic_a0", mem_a, 32'h100);
    step(); step(); step(); step();
    chk("col_ic_done5", {31'b0, ic_done}, 32'h0);
    step(); chk("col_ic_done6", {31'b0, ic_done}, 32'h1);
    chk("col_ic_data", ic_data, 32'h00000513);
    step();

    // store half
    ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'd1;
    ls_addr = 32'h40; ls_wdata = 32'hAABBCCDD;
    step();
    ls_req = 1'b0;
    chk("sh_wr0", {31'b0, mem_wr}, 32'h1);
    chk("sh_a0", mem_a, 32'h40);
    chk("sh_d0", {24'b0, mem_dout}, 32'hDD);
    step();
    chk("sh_wr1", {31'b0, mem_wr}, 32'h1);
    chk("sh_a1", mem_a, 32'h41);
    chk("sh_d1", {24'b0, mem_dout}, 32'hCC);
    step();
    chk("sh_done", {31'b0, ls_done}, 32'h1);
    chk("sh_wr_idle", {31'b0, mem_wr}, 32'h0);
    chk("sh_ram", {16'b0, ram[18'h41], ram[18'h40]}, 32'hCCDD);
    step();

    // IO stall
    io_buffer_full = 1'b1;
    ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'd0;
    ls_addr = 32'h30000; ls_wdata = 32'h0000005A;
    step();
    ls_req = 1'b0;
    chk("io_a", mem_a, 32'h30000);
    chk("io_wr1", {31'b0, mem_wr}, 32'h0);
    step(); chk("io_wr2", {31'b0, mem_wr}, 32'h0);
    step(); chk("io_wr3", {31'b0, mem_wr}, 32'h0);
    chk("io_nodone", {31'b0, ls_done}, 32'h0);
    step();
    io_buffer_full = 1'b0;
    #1;
    chk("io_wr4", {31'b0, mem_wr}, 32'h1);
    chk("io_d4", {24'b0, mem_dout}, 32'h5A);
    step();
    chk("io_done", {31'b0, ls_done}, 32'h1);
    chk("io_wr5", {31'b0, mem_wr}, 32'h0);
    chk("io_ram", {24'b0, ram[18'h30000]}, 32'h5A);
    step();

    // flush during fetch
    ic_req = 1'b1; ic_addr = 32'h300;
    step();
    ic_req = 1'b0;
    step();
    step();
    jump_wrong = 1'b1;
    step();
    jump_wrong = 1'b0;
    chk("fl_nodone", {31'b0, ic_done}, 32'h0);
    chk("fl_data", ic_data, 32'h00000513);
    chk("fl_idle_a", mem_a, 32'h0);
    ic_req = 1'b1; ic_addr = 32'h300;
    step();
    ic_req = 1'b0;
    chk("fl_new_a0", mem_a, 32'h300);
    step(); step(); step(); step();
    step(); chk("fl_done", {31'b0, ic_done}, 32'h1);
    chk("fl_new_data", ic_data, 32'hDEADBEEF);
    step();

    // rdy freeze mid word load
    ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'd2; ls_addr = 32'h50;
    step();
    ls_req = 1'b0;
    step();
    chk("rdy_a1", mem_a, 32'h51);
    rdy = 1'b0;
    step(); chk("rdy_frz_a", mem_a, 32'h51);
    chk("rdy_frz_wr", {31'b0, mem_wr}, 32'h0);
    step(); chk("rdy_frz_a2", mem_a, 32'h51);
    rdy = 1'b1;
    step(); chk("rdy_a2", mem_a, 32'h52);
    step(); step();
    chk("rdy_done7", {31'b0, ls_done}, 32'h0);
    step(); chk("rdy_done8", {31'b0, ls_done}, 32'h1);
    chk("rdy_rdata", ls_rdata, 32'h44332211);
    step();

    // half load wrapping past the top of the address space
    ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'd1; ls_addr = 32'hFFFFFFFF;
    step();
    ls_req = 1'b0;
    chk("wrap_a0", mem_a, 32'hFFFFFFFF);
    step(); chk("wrap_a1", mem_a, 32'h0);
    step(); step();
    chk("wrap_done", {31'b0, ls_done}, 32'h1);
    chk("wrap_rdata", ls_rdata, 32'h00003412);
    step();

    // reset mid-fetch
    ic_req = 1'b1; ic_addr = 32'h100;
    step();
    ic_req = 1'b0;
    step();
    rst = 1'b1;
    step();
    chk("mrst_done", {31'b0, ic_done}, 32'h0);
    chk("mrst_data", ic_data, 32'h0);
    chk("mrst_a", mem_a, 32'h0);
    rst = 1'b0;
    step(); step(); step(); step();
    chk("mrst_nodone", {31'b0, ic_done}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Byte-serial memory controller that sits directly downstream of the ICache and the load/store buffer (LSB), and owns the single 8-bit RAM/IO port.
- Arbitrates between ICache word fetches and LSB loads/stores.
- Serialises each access into 1, 2 or 4 little-endian byte transfers.
- Returns assembled data with a one-cycle done pulse.

Parameters:
- ADDR_WIDTH, 32, width of all address ports.
- IO_SEL_HI, 17, upper bit of the IO-region select field.
- IO_SEL_LO, 16, lower bit of the IO-region select field. An address is IO when addr[IO_SEL_HI:IO_SEL_LO] is all ones.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global enable; low freezes all state
- jump_wrong  in  1  branch mispredict flush
- ic_req  in  1  ICache requests a 4-byte instruction fetch
- ic_addr  in  ADDR_WIDTH  fetch base address
- ic_done  out  1  one-cycle pulse: ic_data valid
- ic_data  out  32  fetched instruction, little-endian
- ls_req  in  1  LSB requests an access
- ls_we  in  1  1 = store, 0 = load
- ls_addr  in  ADDR_WIDTH  access base address
- ls_size  in  2  0 = byte, 1 = half, 2 = word (3 is treated as word)
- ls_wdata  in  32  store data; low bytes used
- ls_done  out  1  one-cycle pulse: access complete, ls_rdata valid for loads
- ls_rdata  out  32  load data, zero-extended (the LSB performs sign extension)
- mem_din  in  8  RAM read byte, valid the cycle after its address
- mem_dout  out  8  RAM write byte
- mem_a  out  ADDR_WIDTH  RAM byte address
- mem_wr  out  1  1 = write cycle
- io_buffer_full  in  1  IO sink cannot accept a write

Behaviour:
- Reset (rst=1 at an edge): state IDLE, cnt=0. All outputs 0: ic_done, ls_done, ic_data, ls_rdata, mem_a, mem_dout, mem_wr.
  - Reset mid-transfer abandons the transfer; no done pulse is issued.
- rdy=0 (and rst=0): state, cnt and data registers hold; mem_wr forced 0; done outputs hold.
- States: IDLE, IC_RD, LS_RD, LS_WR. N = bytes in the access: 4 for IC_RD, 1/2/4 per ls_size for LS states.
- IDLE arbitration, sampled at the edge:
  - ls_req wins over ic_req.
  - A port whose done is high in the current cycle is ignored.
  - ic_req is ignored when jump_wrong=1.
  - On acceptance: latch base address, N and write data; set cnt=0; enter LS_WR, LS_RD or IC_RD.
  - In IDLE, mem_wr=0 and mem_a=0.
- Read states (IC_RD, LS_RD):
  - While cnt<N: mem_a=base+cnt, mem_wr=0.
  - At every edge with cnt>=1, mem_din is stored into byte lane cnt-1.
  - cnt increments each enabled cycle.
  - At the edge where cnt==N: store the last byte, pulse the matching done for the next cycle, return to IDLE.
  - Lanes >= N are 0.
- Write state (LS_WR):
  - Each cycle: mem_wr=1, mem_a=base+cnt, mem_dout=ls_wdata byte cnt.
  - At the edge where cnt==N-1: ls_done pulses next cycle; return to IDLE.
- IO stall: in LS_WR, if the current byte address is IO and io_buffer_full=1, then mem_wr=0 and cnt holds; the transfer resumes when io_buffer_full=0.
- Latency, counted from the accepting edge to the cycle the done pulse is high:
  - Read: N+2 cycles (word fetch 6, byte load 3).
  - Write: N+1 cycles, with no IO stall.
- Address arithmetic wraps modulo 2^ADDR_WIDTH; unaligned bases are allowed.
- jump_wrong=1 in IC_RD: abort to IDLE at that edge; ic_done is not pulsed; ic_data is unchanged.
- jump_wrong has no effect on LS states; the LSB discards stale results itself.
- Done pulses last exactly one cycle. ic_data and ls_rdata hold until the next completion of the same port.
- Requesters deassert req in the cycle their done is high.

Test Plan:
- Word fetch: RAM[0x100..0x103]=13,05,00,00; ic_req, ic_addr=0x100 -> mem_a 0x100..0x103 on consecutive cycles; ic_done high 6 cycles after acceptance; ic_data=0x00000513.
- Collision: ic_req and ls_req (load byte @0x200, RAM=0xFF) in the same cycle -> LS served first; ls_rdata=0x000000FF, ls_done at cycle 3; IC fetch then starts in the next IDLE cycle.
- Store half: ls_we=1, size=1, addr=0x40, wdata=0xAABBCCDD -> mem_wr=1 at 0x40 with 0xDD, then 0x41 with 0xCC; ls_done at cycle 3.
- IO stall: byte store to 0x30000 with io_buffer_full=1 for 3 cycles -> mem_wr held 0 for 3 cycles, then a single write of the byte; ls_done one cycle later.
- Flush: jump_wrong asserted on the 3rd cycle of IC_RD -> returns to IDLE, no ic_done, ic_data keeps its previous value; a new ic_req is accepted the following cycle.
- rdy=0 for 2 cycles mid word-load -> mem_wr=0 and cnt frozen; final ls_rdata still correct, latency extended by 2.
